// File: rtl/mem_port_arbiter_pkg.sv
// rtl/mem_port_arbiter_pkg.sv - shared encodings for the IF/LS memory port arbiter
package mem_port_arbiter_pkg;

  localparam logic [1:0] SIZE_B   = 2'b00;
  localparam logic [1:0] SIZE_H   = 2'b01;
  localparam logic [1:0] SIZE_W   = 2'b10;
  localparam logic [1:0] SIZE_ILL = 2'b11;

  typedef enum logic {
    IDLE    = 1'b0,
    RD_WAIT = 1'b1
  } state_t;

  typedef enum logic {
    REQ_IF = 1'b0,
    REQ_LS = 1'b1
  } req_id_t;

endpackage

// File: rtl/mem_port_arbiter_byte_lane_aligner.sv
// rtl/mem_port_arbiter_byte_lane_aligner.sv - byte enables, lane replication, load shift, misalign detect
module mem_port_arbiter_byte_lane_aligner
  import mem_port_arbiter_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  addr_lo,
  input  logic [1:0]  rd_off,
  input  logic [31:0] wdata,
  input  logic [31:0] mem_rdata,
  output logic [3:0]  be,
  output logic [31:0] lane_wdata,
  output logic [31:0] shifted_rdata,
  output logic        misalign
);

  always_comb begin
    be         = 4'b0000;
    lane_wdata = wdata;
    misalign   = 1'b0;
    case (size)
      SIZE_B: begin
        be         = 4'b0001 << addr_lo;
        lane_wdata = {4{wdata[7:0]}};
      end
      SIZE_H: begin
        be         = addr_lo[1] ? 4'b1100 : 4'b0011;
        lane_wdata = {2{wdata[15:0]}};
        misalign   = addr_lo[0];
      end
      SIZE_W: begin
        be       = 4'b1111;
        misalign = |addr_lo;
      end
      SIZE_ILL: misalign = 1'b1;
    endcase
  end

  // rd_off is the offset captured at grant, not the live request address
  assign shifted_rdata = mem_rdata >> {rd_off, 3'b000};

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one single-port memory between instruction fetch and load/store
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH   = 32,
  parameter int RD_LATENCY   = 1,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  if_req,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  output logic                  if_gnt,
  output logic                  if_rvalid,
  output logic [31:0]           if_rdata,
  input  logic                  ls_req,
  input  logic                  ls_we,
  input  logic [1:0]            ls_size,
  input  logic [ADDR_WIDTH-1:0] ls_addr,
  input  logic [31:0]           ls_wdata,
  output logic                  ls_gnt,
  output logic                  ls_rvalid,
  output logic [31:0]           ls_rdata,
  output logic                  ls_err,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [3:0]            mem_be,
  output logic [ADDR_WIDTH-3:0] mem_addr,
  output logic [31:0]           mem_wdata,
  input  logic [31:0]           mem_rdata
);

  localparam int            SW         = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
  localparam bit            STARVE_EN  = (STARVE_LIMIT != 0);
  localparam logic [1:0]    LAT_INIT   = 2'(RD_LATENCY - 1);

  state_t        state_q, state_d;
  req_id_t       owner_q, owner_d;
  logic [1:0]    lat_q, lat_d;
  logic [1:0]    off_q, off_d;
  logic [SW-1:0] starve_q, starve_d;

  logic [3:0]    be;
  logic [31:0]   lane_wdata;
  logic          misalign;
  logic          rd_done, can_grant, if_win;
  logic          unused_if_lo;

  assign unused_if_lo = ^if_addr[1:0];

  mem_port_arbiter_byte_lane_aligner u_aligner (
    .size          (ls_size),
    .addr_lo       (ls_addr[1:0]),
    .rd_off        (off_q),
    .wdata         (ls_wdata),
    .mem_rdata     (mem_rdata),
    .be            (be),
    .lane_wdata    (lane_wdata),
    .shifted_rdata (ls_rdata),
    .misalign      (misalign)
  );

  // The rvalid cycle frees the port, so a new grant may overlap it
  assign rd_done   = (state_q == RD_WAIT) && (lat_q == 2'd0);
  assign can_grant = rst_n && ((state_q == IDLE) || rd_done);
  assign if_win    = if_req && (!ls_req || (STARVE_EN && (starve_q == STARVE_MAX)));

  assign if_rvalid = rst_n && rd_done && (owner_q == REQ_IF);
  assign ls_rvalid = rst_n && rd_done && (owner_q == REQ_LS);
  assign if_rdata  = mem_rdata;

  always_comb begin
    if_gnt    = 1'b0;
    ls_gnt    = 1'b0;
    ls_err    = 1'b0;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_be    = 4'b0000;
    mem_addr  = '0;
    mem_wdata = '0;
    state_d   = state_q;
    owner_d   = owner_q;
    lat_d     = lat_q;
    off_d     = off_q;
    starve_d  = starve_q;

    if (state_q == RD_WAIT) begin
      if (lat_q == 2'd0) state_d = IDLE;
      else               lat_d   = lat_q - 2'd1;
    end

    if (can_grant && if_win) begin
      if_gnt   = 1'b1;
      mem_en   = 1'b1;
      mem_addr = if_addr[ADDR_WIDTH-1:2];
      state_d  = RD_WAIT;
      lat_d    = LAT_INIT;
      owner_d  = REQ_IF;
    end else if (can_grant && ls_req) begin
      ls_gnt = 1'b1;
      if (misalign) begin
        ls_err = 1'b1;
      end else begin
        mem_en   = 1'b1;
        mem_we   = ls_we;
        mem_addr = ls_addr[ADDR_WIDTH-1:2];
        if (ls_we) begin
          mem_be    = be;
          mem_wdata = lane_wdata;
        end else begin
          state_d = RD_WAIT;
          lat_d   = LAT_INIT;
          owner_d = REQ_LS;
          off_d   = ls_addr[1:0];
        end
      end
    end

    if (if_gnt)                                   starve_d = '0;
    else if (if_req && (starve_q != STARVE_MAX))  starve_d = starve_q + SW'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      owner_q  <= REQ_IF;
      lat_q    <= 2'd0;
      off_q    <= 2'd0;
      starve_q <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      lat_q    <= lat_d;
      off_q    <= off_d;
      starve_q <= starve_d;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;
  localparam int AW = 32;

  typedef struct packed {
    logic        is_ls;
    logic [31:0] data;
  } exp_t;

  typedef struct packed {
    logic        we;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] exp;
  } ls_vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic          if_req, if_gnt, if_rvalid;
  logic [AW-1:0] if_addr;
  logic [31:0]   if_rdata;
  logic          ls_req, ls_we, ls_gnt, ls_rvalid, ls_err;
  logic [1:0]    ls_size;
  logic [AW-1:0] ls_addr;
  logic [31:0]   ls_wdata, ls_rdata;
  logic          mem_en, mem_we;
  logic [3:0]    mem_be;
  logic [AW-3:0] mem_addr;
  logic [31:0]   mem_wdata, mem_rdata;

  logic          rst3_n, if_req3, if_gnt3, if_rvalid3, ls_gnt3, ls_rvalid3, ls_err3, mem_en3, mem_we3;
  logic [AW-1:0] if_addr3;
  logic [31:0]   if_rdata3, unused_ls_rdata3, unused_mem_wdata3, mem_rdata3;
  logic [3:0]    mem_be3;
  logic [AW-3:0] mem_addr3;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  mem_port_arbiter #(.ADDR_WIDTH(AW), .RD_LATENCY(1), .STARVE_LIMIT(4)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .ls_req(ls_req), .ls_we(ls_we), .ls_size(ls_size), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
    .ls_gnt(ls_gnt), .ls_rvalid(ls_rvalid), .ls_rdata(ls_rdata), .ls_err(ls_err),
    .mem_en(mem_en), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  mem_port_arbiter #(.ADDR_WIDTH(AW), .RD_LATENCY(3), .STARVE_LIMIT(0)) u_dut3 (
    .clk(clk), .rst_n(rst3_n),
    .if_req(if_req3), .if_addr(if_addr3), .if_gnt(if_gnt3), .if_rvalid(if_rvalid3), .if_rdata(if_rdata3),
    .ls_req(1'b0), .ls_we(1'b0), .ls_size(2'b10), .ls_addr(32'h0), .ls_wdata(32'h0),
    .ls_gnt(ls_gnt3), .ls_rvalid(ls_rvalid3), .ls_rdata(unused_ls_rdata3), .ls_err(ls_err3),
    .mem_en(mem_en3), .mem_we(mem_we3), .mem_be(mem_be3), .mem_addr(mem_addr3),
    .mem_wdata(unused_mem_wdata3), .mem_rdata(mem_rdata3)
  );

  assign mem_rdata3 = 32'hCAFEF00D;

  logic [31:0] mem [0:255];
  always @(posedge clk) begin
    if (mem_en && mem_we) begin
      for (int b = 0; b < 4; b++)
        if (mem_be[b]) mem[mem_addr[7:0]][8*b +: 8] <= mem_wdata[8*b +: 8];
    end
    if (mem_en && !mem_we) mem_rdata <= mem[mem_addr[7:0]];
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_rvalid(output int lat);
    lat = -1;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (if_rvalid || ls_rvalid) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; rst3_n = 1'b0;
    if_req = 1'b1; if_addr = 32'h100;
    ls_req = 1'b1; ls_we = 1'b1; ls_size = 2'b10; ls_addr = 32'h0; ls_wdata = 32'hFFFFFFFF;
    step(); step();
    @(negedge clk);
    n_cmp++;
    if ({if_gnt, ls_gnt, ls_err, mem_en, mem_we, mem_be, if_rvalid, ls_rvalid} !== 11'b0) begin
      n_bad++;
      $display("FAIL reset_outputs: got %b expected %b",
               {if_gnt, ls_gnt, ls_err, mem_en, mem_we, mem_be, if_rvalid, ls_rvalid}, 11'b0);
    end
    n_cmp++;
    if ({if_gnt3, if_rvalid3, mem_en3} !== 3'b0) begin
      n_bad++;
      $display("FAIL reset_outputs_lat3: got %b expected 000", {if_gnt3, if_rvalid3, mem_en3});
    end
    step();
    if_req = 1'b0; ls_req = 1'b0; rst_n = 1'b1; rst3_n = 1'b1;
    step();
  endtask

  task automatic test_store_word();
    ls_req = 1'b1; ls_we = 1'b1; ls_size = 2'b10; ls_addr = 32'h100; ls_wdata = 32'hDEADBEEF;
    @(negedge clk);
    n_cmp++;
    if ({ls_gnt, if_gnt, ls_err, mem_en, mem_we, mem_be} !== 9'b1_0_0_1_1_1111) begin
      n_bad++;
      $display("FAIL store_word_ctrl: got %b expected %b",
               {ls_gnt, if_gnt, ls_err, mem_en, mem_we, mem_be}, 9'b1_0_0_1_1_1111);
    end
    n_cmp++;
    if (mem_addr !== 30'h40 || mem_wdata !== 32'hDEADBEEF) begin
      n_bad++;
      $display("FAIL store_word_bus: got addr %h data %h expected addr 40 data deadbeef", mem_addr, mem_wdata);
    end
    step();
    ls_req = 1'b0;
    step();
  endtask

  task automatic test_store_lanes();
    ls_vec_t v [5];
    v[0] = '{1'b1, 2'b00, 32'h103, 32'h123456A5, 4'b1000, 32'hA5A5A5A5};
    v[1] = '{1'b1, 2'b01, 32'h102, 32'hFFFF1234, 4'b1100, 32'h12341234};
    v[2] = '{1'b1, 2'b00, 32'h101, 32'h0000007E, 4'b0010, 32'h7E7E7E7E};
    v[3] = '{1'b1, 2'b01, 32'h100, 32'h0000BEEF, 4'b0011, 32'hBEEFBEEF};
    v[4] = '{1'b1, 2'b10, 32'h000, 32'h11223344, 4'b1111, 32'h11223344};
    for (int i = 0; i < 5; i++) begin
      ls_req = 1'b1; ls_we = v[i].we; ls_size = v[i].size; ls_addr = v[i].addr; ls_wdata = v[i].wdata;
      @(negedge clk);
      n_cmp++;
      if ({ls_gnt, ls_err, mem_en, mem_we, mem_be} !== {4'b1011, v[i].be}) begin
        n_bad++;
        $display("FAIL store_lane_ctrl[%0d]: got %b expected %b", i,
                 {ls_gnt, ls_err, mem_en, mem_we, mem_be}, {4'b1011, v[i].be});
      end
      n_cmp++;
      if (mem_wdata !== v[i].exp || mem_addr !== v[i].addr[31:2]) begin
        n_bad++;
        $display("FAIL store_lane_bus[%0d]: got data %h addr %h expected data %h addr %h", i,
                 mem_wdata, mem_addr, v[i].exp, v[i].addr[31:2]);
      end
      step();
      ls_req = 1'b0;
      step();
    end
  endtask

  task automatic test_load();
    ls_vec_t v [6];
    exp_t    e;
    int      lat;
    logic [31:0] got;
    v[0] = '{1'b0, 2'b01, 32'h002, 32'h0, 4'b0000, 32'h00001122};
    v[1] = '{1'b0, 2'b00, 32'h003, 32'h0, 4'b0000, 32'h00000011};
    v[2] = '{1'b0, 2'b00, 32'h001, 32'h0, 4'b0000, 32'h00112233};
    v[3] = '{1'b0, 2'b10, 32'h000, 32'h0, 4'b0000, 32'h11223344};
    v[4] = '{1'b0, 2'b01, 32'h000, 32'h0, 4'b0000, 32'h11223344};
    v[5] = '{1'b0, 2'b10, 32'h100, 32'h0, 4'b0000, 32'h1234BEEF};
    for (int i = 0; i < 6; i++) begin
      ls_req = 1'b1; ls_we = 1'b0; ls_size = v[i].size; ls_addr = v[i].addr; ls_wdata = 32'hFFFFFFFF;
      @(negedge clk);
      n_cmp++;
      if ({ls_gnt, if_gnt, ls_err, mem_en, mem_we, mem_be} !== 9'b1_0_0_1_0_0000 || mem_addr !== v[i].addr[31:2]) begin
        n_bad++;
        $display("FAIL load_grant[%0d]: got %b addr %h expected %b addr %h", i,
                 {ls_gnt, if_gnt, ls_err, mem_en, mem_we, mem_be}, mem_addr, 9'b1_0_0_1_0_0000, v[i].addr[31:2]);
      end
      e.is_ls = 1'b1; e.data = v[i].exp;
      exp_q.push_back(e);
      step();
      ls_req = 1'b0;
      wait_rvalid(lat);
      n_cmp++;
      if (lat != 1) begin
        n_bad++;
        $display("FAIL load_latency[%0d]: got %0d expected 1", i, lat);
      end
      e = exp_q.pop_front();
      if (lat > 0) begin
        got = e.is_ls ? ls_rdata : if_rdata;
        n_cmp++;
        if ({if_rvalid, ls_rvalid} !== {~e.is_ls, e.is_ls} || got !== e.data) begin
          n_bad++;
          $display("FAIL load_rdata[%0d]: got rvalid %b data %h expected rvalid %b data %h", i,
                   {if_rvalid, ls_rvalid}, got, {~e.is_ls, e.is_ls}, e.data);
        end
      end
      @(negedge clk);
      n_cmp++;
      if ({if_rvalid, ls_rvalid} !== 2'b00) begin
        n_bad++;
        $display("FAIL load_pulse[%0d]: got %b expected 00", i, {if_rvalid, ls_rvalid});
      end
      step();
    end
  endtask

  task automatic test_starve();
    int   mcnt = 0;
    int   ls_first = 0;
    bit   seen_if = 1'b0;
    exp_t e;
    if_req = 1'b1; if_addr = 32'h100;
    ls_req = 1'b1; ls_we = 1'b1; ls_size = 2'b10; ls_addr = 32'h200; ls_wdata = 32'h5555AAAA;
    for (int c = 0; c < 10; c++) begin
      bit exp_if;
      @(negedge clk);
      exp_if = (mcnt >= 4);
      n_cmp++;
      if ({if_gnt, ls_gnt} !== {exp_if, ~exp_if}) begin
        n_bad++;
        $display("FAIL starve_grant[%0d]: got if/ls %b expected %b", c, {if_gnt, ls_gnt}, {exp_if, ~exp_if});
      end
      if ((if_rvalid || ls_rvalid) && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_cmp++;
        if (if_rvalid !== 1'b1 || ls_rvalid !== 1'b0 || if_rdata !== e.data) begin
          n_bad++;
          $display("FAIL starve_fetch[%0d]: got rvalid %b data %h expected rvalid 10 data %h", c,
                   {if_rvalid, ls_rvalid}, if_rdata, e.data);
        end
      end
      if (exp_if) begin
        e.is_ls = 1'b0; e.data = 32'h1234BEEF;
        exp_q.push_back(e);
        mcnt = 0;
      end else if (mcnt < 4) begin
        mcnt++;
      end
      if (!seen_if) begin
        if (ls_gnt) ls_first++;
        if (if_gnt) seen_if = 1'b1;
      end
      step();
    end
    if_req = 1'b0; ls_req = 1'b0;
    @(negedge clk);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_cmp++;
      if (if_rvalid !== 1'b1 || if_rdata !== e.data) begin
        n_bad++;
        $display("FAIL starve_last_fetch: got rvalid %b data %h expected 1 %h", if_rvalid, if_rdata, e.data);
      end
    end
    n_cmp++;
    if (ls_first != 4) begin
      n_bad++;
      $display("FAIL starve_ls_run: got %0d expected 4", ls_first);
    end
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL starve_pending: got %0d expected 0", exp_q.size());
      exp_q.delete();
    end
    step();
  endtask

  task automatic test_back_to_back();
    exp_t e;
    ls_req = 1'b1; ls_we = 1'b0; ls_size = 2'b10; ls_addr = 32'h0;
    @(negedge clk);
    n_cmp++;
    if (ls_gnt !== 1'b1) begin
      n_bad++;
      $display("FAIL b2b_ls_gnt: got %b expected 1", ls_gnt);
    end
    e.is_ls = 1'b1; e.data = 32'h11223344;
    exp_q.push_back(e);
    step();
    ls_req = 1'b0; if_req = 1'b1; if_addr = 32'h100;
    @(negedge clk);
    n_cmp++;
    if ({ls_rvalid, if_gnt, ls_gnt} !== 3'b110) begin
      n_bad++;
      $display("FAIL b2b_overlap: got %b expected 110", {ls_rvalid, if_gnt, ls_gnt});
    end
    e = exp_q.pop_front();
    n_cmp++;
    if (ls_rdata !== e.data) begin
      n_bad++;
      $display("FAIL b2b_ls_rdata: got %h expected %h", ls_rdata, e.data);
    end
    e.is_ls = 1'b0; e.data = 32'h1234BEEF;
    exp_q.push_back(e);
    step();
    if_req = 1'b0;
    @(negedge clk);
    e = exp_q.pop_front();
    n_cmp++;
    if ({if_rvalid, ls_rvalid} !== 2'b10 || if_rdata !== e.data) begin
      n_bad++;
      $display("FAIL b2b_if_rdata: got rvalid %b data %h expected 10 %h", {if_rvalid, ls_rvalid}, if_rdata, e.data);
    end
    step();
  endtask

  task automatic test_misalign();
    ls_vec_t v [6];
    bit seen;
    v[0] = '{1'b0, 2'b10, 32'h006, 32'h0, 4'b0000, 32'h0};
    v[1] = '{1'b0, 2'b01, 32'h001, 32'h0, 4'b0000, 32'h0};
    v[2] = '{1'b1, 2'b10, 32'h002, 32'h0, 4'b0000, 32'h0};
    v[3] = '{1'b0, 2'b11, 32'h000, 32'h0, 4'b0000, 32'h0};
    v[4] = '{1'b1, 2'b11, 32'h004, 32'h0, 4'b0000, 32'h0};
    v[5] = '{1'b1, 2'b01, 32'h003, 32'h0, 4'b0000, 32'h0};
    for (int i = 0; i < 6; i++) begin
      ls_req = 1'b1; ls_we = v[i].we; ls_size = v[i].size; ls_addr = v[i].addr; ls_wdata = 32'h87654321;
      @(negedge clk);
      n_cmp++;
      if ({ls_gnt, ls_err, mem_en, mem_we, mem_be} !== 8'b1100_0000) begin
        n_bad++;
        $display("FAIL misalign_ctrl[%0d]: got %b expected %b", i, {ls_gnt, ls_err, mem_en, mem_we, mem_be}, 8'b1100_0000);
      end
      step();
      ls_req = 1'b0;
      seen = 1'b0;
      for (int k = 0; k < 4; k++) begin
        @(negedge clk);
        seen |= (ls_rvalid | if_rvalid | ls_err);
      end
      n_cmp++;
      if (seen !== 1'b0) begin
        n_bad++;
        $display("FAIL misalign_no_rvalid[%0d]: got %b expected 0", i, seen);
      end
      step();
    end
  endtask

  task automatic test_reset_mid_read();
    bit   seen;
    int   lat;
    exp_t e;
    if_req3 = 1'b1; if_addr3 = 32'h40;
    @(negedge clk);
    n_cmp++;
    if ({if_gnt3, mem_en3, mem_we3} !== 3'b110 || mem_addr3 !== 30'h10) begin
      n_bad++;
      $display("FAIL lat3_grant: got %b addr %h expected 110 addr 10", {if_gnt3, mem_en3, mem_we3}, mem_addr3);
    end
    step();
    @(negedge clk);
    n_cmp++;
    if ({if_gnt3, mem_en3} !== 2'b00) begin
      n_bad++;
      $display("FAIL lat3_blocked: got %b expected 00", {if_gnt3, mem_en3});
    end
    step();
    rst3_n = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({if_gnt3, if_rvalid3, ls_gnt3, ls_rvalid3, ls_err3, mem_en3, mem_we3, mem_be3} !== 11'b0) begin
      n_bad++;
      $display("FAIL lat3_reset_outputs: got %b expected %b",
               {if_gnt3, if_rvalid3, ls_gnt3, ls_rvalid3, ls_err3, mem_en3, mem_we3, mem_be3}, 11'b0);
    end
    step();
    rst3_n = 1'b1; if_req3 = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      seen |= (if_rvalid3 | ls_rvalid3);
    end
    n_cmp++;
    if (seen !== 1'b0) begin
      n_bad++;
      $display("FAIL lat3_dropped_read: got rvalid %b expected 0", seen);
    end
    step();
    if_req3 = 1'b1; if_addr3 = 32'h80;
    @(negedge clk);
    n_cmp++;
    if (if_gnt3 !== 1'b1 || mem_addr3 !== 30'h20) begin
      n_bad++;
      $display("FAIL lat3_regrant: got gnt %b addr %h expected 1 addr 20", if_gnt3, mem_addr3);
    end
    e.is_ls = 1'b0; e.data = 32'hCAFEF00D;
    exp_q.push_back(e);
    step();
    if_req3 = 1'b0;
    lat = -1;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (if_rvalid3) begin
        lat = i;
        break;
      end
    end
    e = exp_q.pop_front();
    n_cmp++;
    if (lat != 3 || if_rdata3 !== e.data) begin
      n_bad++;
      $display("FAIL lat3_return: got latency %0d data %h expected 3 %h", lat, if_rdata3, e.data);
    end
    step();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; rst3_n = 1'b0;
    if_req = 1'b0; if_addr = '0;
    ls_req = 1'b0; ls_we = 1'b0; ls_size = 2'b00; ls_addr = '0; ls_wdata = '0;
    if_req3 = 1'b0; if_addr3 = '0;
    test_reset();
    test_store_word();
    test_store_lanes();
    test_load();
    test_starve();
    test_back_to_back();
    test_misalign();
    test_reset_mid_read();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
